// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the IF-stage branch predictor.
// Counter encodings, field widths and the saturating counter step.
package branch_predictor_pkg;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned CTR_W = 2;

    typedef enum logic [CTR_W-1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    function automatic logic [CTR_W-1:0] ctr_step(
        input logic [CTR_W-1:0] c,
        input logic             taken
    );
        logic [CTR_W-1:0] r;
        r = c;
        if (taken) begin
            if (c != ST) r = c + 2'd1;
        end else begin
            if (c != SNT) r = c - 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/branch_predictor_btb_array.sv
// Direct-mapped BTB storage: two combinational read ports
// (fetch lookup, EX tag check) and one synchronous write port.
module btb_array
    import branch_predictor_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned TAG_W      = 30 - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] ra_idx_i,
    output logic                  ra_valid_o,
    output logic [TAG_W-1:0]      ra_tag_o,
    output logic [PC_W-1:0]       ra_target_o,
    output logic [CTR_W-1:0]      ra_ctr_o,
    output logic                  ra_jump_o,
    input  logic [INDEX_BITS-1:0] rb_idx_i,
    output logic                  rb_valid_o,
    output logic [TAG_W-1:0]      rb_tag_o,
    output logic [PC_W-1:0]       rb_target_o,
    output logic [CTR_W-1:0]      rb_ctr_o,
    output logic                  rb_jump_o,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic                  wr_valid_i,
    input  logic [TAG_W-1:0]      wr_tag_i,
    input  logic [PC_W-1:0]       wr_target_i,
    input  logic [CTR_W-1:0]      wr_ctr_i,
    input  logic                  wr_jump_i
);

    localparam int unsigned N = 1 << INDEX_BITS;

    logic [N-1:0]     valid_q;
    logic [N-1:0]     jump_q;
    logic [TAG_W-1:0] tag_q    [N];
    logic [PC_W-1:0]  target_q [N];
    logic [CTR_W-1:0] ctr_q    [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            jump_q  <= '0;
            for (int i = 0; i < int'(N); i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WNT;
            end
        end else if (we_i) begin
            valid_q[wr_idx_i]  <= wr_valid_i;
            jump_q[wr_idx_i]   <= wr_jump_i;
            tag_q[wr_idx_i]    <= wr_tag_i;
            target_q[wr_idx_i] <= wr_target_i;
            ctr_q[wr_idx_i]    <= wr_ctr_i;
        end
    end

    assign ra_valid_o  = valid_q[ra_idx_i];
    assign ra_tag_o    = tag_q[ra_idx_i];
    assign ra_target_o = target_q[ra_idx_i];
    assign ra_ctr_o    = ctr_q[ra_idx_i];
    assign ra_jump_o   = jump_q[ra_idx_i];

    assign rb_valid_o  = valid_q[rb_idx_i];
    assign rb_tag_o    = tag_q[rb_idx_i];
    assign rb_target_o = target_q[rb_idx_i];
    assign rb_ctr_o    = ctr_q[rb_idx_i];
    assign rb_jump_o   = jump_q[rb_idx_i];

endmodule

// File: rtl/branch_predictor.sv
// IF-stage dynamic branch predictor: BTB lookup, EX-side mispredict
// detection and redirect, table training and statistics counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc_i,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        ex_valid_i,
    input  logic [31:0] ex_pc_i,
    input  logic        ex_is_branch_i,
    input  logic        ex_is_jump_i,
    input  logic        ex_taken_i,
    input  logic [31:0] ex_target_i,
    input  logic        ex_pred_taken_i,
    input  logic [31:0] ex_pred_target_i,
    output logic        mispredict_o,
    output logic [31:0] redirect_pc_o,
    output logic [31:0] branch_cnt_o,
    output logic [31:0] mispred_cnt_o
);

    localparam int unsigned TAG_W = 30 - INDEX_BITS;

    logic [INDEX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0]      if_tag, ex_tag;

    logic             a_valid, a_jump;
    logic [TAG_W-1:0] a_tag;
    logic [PC_W-1:0]  a_target;
    logic [CTR_W-1:0] a_ctr;

    logic             b_valid, b_jump;
    logic [TAG_W-1:0] b_tag;
    logic [PC_W-1:0]  b_target;
    logic [CTR_W-1:0] b_ctr;

    logic             we;
    logic             wr_valid, wr_jump;
    logic [TAG_W-1:0] wr_tag;
    logic [PC_W-1:0]  wr_target;
    logic [CTR_W-1:0] wr_ctr;

    logic        if_hit, ex_hit, cf;
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;
    logic        unused_pc_lsb;

    assign if_idx = if_pc_i[INDEX_BITS+1:2];
    assign if_tag = if_pc_i[31:INDEX_BITS+2];
    assign ex_idx = ex_pc_i[INDEX_BITS+1:2];
    assign ex_tag = ex_pc_i[31:INDEX_BITS+2];
    assign unused_pc_lsb = ^{if_pc_i[1:0], ex_pc_i[1:0]};

    btb_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W)
    ) u_btb (
        .clk         (clk),
        .rst_n       (rst_n),
        .ra_idx_i    (if_idx),
        .ra_valid_o  (a_valid),
        .ra_tag_o    (a_tag),
        .ra_target_o (a_target),
        .ra_ctr_o    (a_ctr),
        .ra_jump_o   (a_jump),
        .rb_idx_i    (ex_idx),
        .rb_valid_o  (b_valid),
        .rb_tag_o    (b_tag),
        .rb_target_o (b_target),
        .rb_ctr_o    (b_ctr),
        .rb_jump_o   (b_jump),
        .we_i        (we),
        .wr_idx_i    (ex_idx),
        .wr_valid_i  (wr_valid),
        .wr_tag_i    (wr_tag),
        .wr_target_i (wr_target),
        .wr_ctr_i    (wr_ctr),
        .wr_jump_i   (wr_jump)
    );

    assign if_hit        = a_valid && (a_tag == if_tag);
    assign pred_taken_o  = if_hit && (a_jump || a_ctr[1]);
    assign pred_target_o = pred_taken_o ? a_target : if_pc_i + 32'd4;

    assign cf     = ex_is_branch_i || ex_is_jump_i;
    assign ex_hit = b_valid && (b_tag == ex_tag);

    assign mispredict_o = ex_valid_i &&
        ((ex_taken_i != ex_pred_taken_i) ||
         (ex_taken_i && (ex_target_i != ex_pred_target_i)));
    assign redirect_pc_o = ex_taken_i ? ex_target_i : ex_pc_i + 32'd4;

    // Read-modify-write of the EX entry; fields not touched keep old values
    always_comb begin
        we        = 1'b0;
        wr_valid  = b_valid;
        wr_tag    = b_tag;
        wr_target = b_target;
        wr_ctr    = b_ctr;
        wr_jump   = b_jump;
        if (ex_valid_i) begin
            if (cf && ex_hit) begin
                we      = 1'b1;
                wr_ctr  = ctr_step(b_ctr, ex_taken_i);
                wr_jump = ex_is_jump_i;
                if (ex_taken_i) wr_target = ex_target_i;
            end else if (cf && ex_taken_i) begin
                we        = 1'b1;
                wr_valid  = 1'b1;
                wr_tag    = ex_tag;
                wr_target = ex_target_i;
                wr_ctr    = WT;
                wr_jump   = ex_is_jump_i;
            end else if (!cf && ex_hit) begin
                we       = 1'b1;
                wr_valid = 1'b0;
            end
        end
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (ex_valid_i && cf && (branch_cnt_q != '1))
            branch_cnt_d = branch_cnt_q + 32'd1;
        if (mispredict_o && (mispred_cnt_q != '1))
            mispred_cnt_d = mispred_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor against a table model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid, ex_br, ex_jmp, ex_taken, ex_ptaken;
    logic [31:0] ex_pc, ex_target, ex_ptarget;
    logic        mispredict;
    logic [31:0] redirect_pc, branch_cnt, mispred_cnt;

    always #5 clk = ~clk;

    branch_predictor #(.INDEX_BITS(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc_i          (if_pc),
        .pred_taken_o     (pred_taken),
        .pred_target_o    (pred_target),
        .ex_valid_i       (ex_valid),
        .ex_pc_i          (ex_pc),
        .ex_is_branch_i   (ex_br),
        .ex_is_jump_i     (ex_jmp),
        .ex_taken_i       (ex_taken),
        .ex_target_i      (ex_target),
        .ex_pred_taken_i  (ex_ptaken),
        .ex_pred_target_i (ex_ptarget),
        .mispredict_o     (mispredict),
        .redirect_pc_o    (redirect_pc),
        .branch_cnt_o     (branch_cnt),
        .mispred_cnt_o    (mispred_cnt)
    );

    int checks = 0;
    int failures = 0;

    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    bit          m_jmp   [16];
    longint      m_bc, m_mc;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0;
            m_ctr[i] = 1;   m_jmp[i] = 0;
        end
        m_bc = 0; m_mc = 0;
    endtask

    task automatic model_pred(input logic [31:0] pc, output logic t,
                              output logic [31:0] tg);
        int i;
        bit hit;
        i = int'((pc / 4) % 16);
        hit = m_valid[i] && (m_tag[i] == pc / 64);
        t = hit && (m_jmp[i] || m_ctr[i] >= 2);
        tg = t ? m_tgt[i] : pc + 32'd4;
    endtask

    function automatic bit exp_mis();
        return ex_valid && ((ex_taken != ex_ptaken) ||
                            (ex_taken && ex_target != ex_ptarget));
    endfunction

    task automatic model_update();
        int i;
        bit hit, cf;
        if (!ex_valid) return;
        cf = ex_br || ex_jmp;
        i = int'((ex_pc / 4) % 16);
        hit = m_valid[i] && (m_tag[i] == ex_pc / 64);
        if (cf && m_bc < 64'hFFFF_FFFF) m_bc++;
        if (exp_mis() && m_mc < 64'hFFFF_FFFF) m_mc++;
        if (cf && hit) begin
            m_ctr[i] = ex_taken ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                                : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
            if (ex_taken) m_tgt[i] = ex_target;
            m_jmp[i] = ex_jmp;
        end else if (cf && ex_taken) begin
            m_valid[i] = 1; m_tag[i] = ex_pc / 64; m_tgt[i] = ex_target;
            m_ctr[i] = 2;   m_jmp[i] = ex_jmp;
        end else if (!cf && hit) begin
            m_valid[i] = 0;
        end
    endtask

    // Compare every output against the model, then advance one clock
    task automatic tick();
        logic t;
        logic [31:0] tg;
        #1;
        model_pred(if_pc, t, tg);
        chk("pred_taken", pred_taken, t);
        chk("pred_target", pred_target, tg);
        chk("mispredict", mispredict, exp_mis());
        chk("redirect", redirect_pc,
            ex_taken ? ex_target : ex_pc + 32'd4);
        chk("branch_cnt", branch_cnt, m_bc[31:0]);
        chk("mispred_cnt", mispred_cnt, m_mc[31:0]);
        @(posedge clk);
        if (rst_n) model_update();
        @(negedge clk);
    endtask

    task automatic ex_set(input logic [31:0] pc, input bit br, input bit jmp,
                          input bit taken, input logic [31:0] tgt);
        logic t;
        logic [31:0] tg;
        model_pred(pc, t, tg);
        ex_valid = 1; ex_pc = pc; ex_br = br; ex_jmp = jmp;
        ex_taken = taken; ex_target = tgt;
        ex_ptaken = t; ex_ptarget = tg;
    endtask

    task automatic ex_idle();
        ex_valid = 0; ex_pc = 0; ex_br = 0; ex_jmp = 0;
        ex_taken = 0; ex_target = 0; ex_ptaken = 0; ex_ptarget = 0;
    endtask

    // Train one branch at pc, then look it up in the following cycle
    task automatic train(input logic [31:0] pc, input bit taken,
                         input bit exp_t, input string name);
        ex_set(pc, 1, 0, taken, 32'h80);
        if_pc = pc;
        tick();
        ex_idle();
        #1 chk(name, pred_taken, exp_t);
        tick();
    endtask

    logic [31:0] pool [8];

    initial begin
        pool[0] = 32'h100; pool[1] = 32'h140; pool[2] = 32'h200;
        pool[3] = 32'h284; pool[4] = 32'h3C0; pool[5] = 32'hFFFF_FFFC;
        pool[6] = 32'h104; pool[7] = 32'h1C0;

        rst_n = 0; if_pc = 32'h100; ex_idle(); model_reset();
        #1;
        chk("reset_pred_taken", pred_taken, 1'b0);
        chk("reset_pred_target", pred_target, 32'h104);
        chk("reset_branch_cnt", branch_cnt, 32'h0);
        chk("reset_mispred_cnt", mispred_cnt, 32'h0);
        #10;
        @(negedge clk);
        rst_n = 1;
        tick();

        ex_set(32'h100, 1, 0, 1, 32'h80);
        #1;
        chk("beq_mispredict", mispredict, 1'b1);
        chk("beq_redirect", redirect_pc, 32'h80);
        tick();
        ex_idle();
        #1;
        chk("beq_lookup_taken", pred_taken, 1'b1);
        chk("beq_lookup_target", pred_target, 32'h80);
        chk("beq_mispred_cnt", mispred_cnt, 32'd1);
        tick();

        train(32'h100, 0, 0, "hyst_nt1");
        train(32'h100, 0, 0, "hyst_nt2");
        train(32'h100, 1, 0, "hyst_t1");
        train(32'h100, 1, 1, "hyst_t2");
        for (int k = 0; k < 3; k++) train(32'h100, 1, 1, "hyst_sat");

        ex_set(32'h200, 0, 1, 1, 32'h400);
        tick();
        ex_idle(); if_pc = 32'h200;
        #1;
        chk("jal_pred_taken", pred_taken, 1'b1);
        chk("jal_pred_target", pred_target, 32'h400);
        tick();
        ex_set(32'h200, 0, 1, 1, 32'h400);
        #1 chk("jal_correct_nomis", mispredict, 1'b0);
        tick();

        ex_set(32'h284, 1, 0, 1, 32'h300);
        tick();
        ex_set(32'h284, 1, 0, 1, 32'h304);
        #1;
        chk("wrongtgt_ptaken", ex_ptarget, 32'h300);
        chk("wrongtgt_mispredict", mispredict, 1'b1);
        chk("wrongtgt_redirect", redirect_pc, 32'h304);
        tick();
        ex_idle(); if_pc = 32'h284;
        #1 chk("wrongtgt_newtgt", pred_target, 32'h304);
        tick();

        ex_set(32'h100, 1, 0, 1, 32'h80);
        tick();
        ex_set(32'h140, 1, 0, 1, 32'h500);
        if_pc = 32'h100;
        #1 chk("alias_same_cycle_old", pred_target, 32'h80);
        tick();
        ex_idle();
        #1 chk("alias_evicted", pred_target, 32'h104);
        tick();
        ex_set(32'h140, 0, 0, 0, 32'h0);
        tick();
        ex_idle(); if_pc = 32'h140;
        #1 chk("stale_invalidated", pred_taken, 1'b0);
        tick();

        for (int n = 0; n < 600; n++) begin
            int r;
            logic [31:0] pc, tg;
            pc = pool[$urandom_range(0, 7)];
            r = $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0: tg = 32'h80;
                1: tg = 32'h300;
                2: tg = 32'h304;
                default: tg = $urandom & 32'hFFFF_FFFC;
            endcase
            if (r == 0) ex_set(pc, 0, 0, 0, tg);
            else if (r == 1) ex_set(pc, 0, 1, 1, tg);
            else ex_set(pc, 1, 0, 1'($urandom_range(0, 1)), tg);
            if ($urandom_range(0, 9) < 2) ex_valid = 0;
            if ($urandom_range(0, 9) == 0) ex_ptaken = ~ex_ptaken;
            if ($urandom_range(0, 9) == 0) ex_ptarget = ex_ptarget + 32'd8;
            if_pc = pool[$urandom_range(0, 7)];
            tick();
        end

        ex_set(32'h3C0, 1, 0, 1, 32'h900);
        if_pc = 32'h3C0;
        #2 rst_n = 0;
        #1;
        chk("midreset_branch_cnt", branch_cnt, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        foreach (pool[k]) begin
            if_pc = pool[k];
            #0.1 chk("midreset_miss", pred_taken, 1'b0);
        end
        @(negedge clk);
        ex_idle();
        rst_n = 1;
        if_pc = 32'h3C0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
